// File: rtl/mips_alu_pkg.sv
// Shared operation codes for the MIPS ALU and its control decoder.
// HI/LO codes 17-24 are only honoured when MIPS_ALU_MULDIV_EN is defined.
package mips_alu_pkg;

  localparam logic [4:0] OP_AND   = 5'd0;
  localparam logic [4:0] OP_OR    = 5'd1;
  localparam logic [4:0] OP_ADD   = 5'd2;
  localparam logic [4:0] OP_ADDU  = 5'd3;
  localparam logic [4:0] OP_SUB   = 5'd4;
  localparam logic [4:0] OP_SUBU  = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_NOR   = 5'd8;
  localparam logic [4:0] OP_XOR   = 5'd9;
  localparam logic [4:0] OP_SLL   = 5'd10;
  localparam logic [4:0] OP_SRL   = 5'd11;
  localparam logic [4:0] OP_SRA   = 5'd12;
  localparam logic [4:0] OP_SLLV  = 5'd13;
  localparam logic [4:0] OP_SRLV  = 5'd14;
  localparam logic [4:0] OP_SRAV  = 5'd15;
  localparam logic [4:0] OP_LUI   = 5'd16;
  localparam logic [4:0] OP_MFHI  = 5'd17;
  localparam logic [4:0] OP_MFLO  = 5'd18;
  localparam logic [4:0] OP_MTHI  = 5'd19;
  localparam logic [4:0] OP_MTLO  = 5'd20;
  localparam logic [4:0] OP_MULT  = 5'd21;
  localparam logic [4:0] OP_MULTU = 5'd22;
  localparam logic [4:0] OP_DIV   = 5'd23;
  localparam logic [4:0] OP_DIVU  = 5'd24;
  localparam logic [4:0] OP_SLTZ  = 5'd25;
  localparam logic [4:0] OP_SGTZ  = 5'd26;

  // Codes that only update HI/LO and therefore drive a zero result.
  function automatic logic is_hilo_write(input logic [4:0] op);
    return (op >= OP_MTHI) && (op <= OP_DIVU);
  endfunction

endpackage

// File: rtl/mips_alu_muldiv.sv
// HI/LO storage with single-cycle multiply/divide; updated on every edge the code is present.
// Instantiated by mips_alu only when MIPS_ALU_MULDIV_EN is defined.
module mips_alu_muldiv
  import mips_alu_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [4:0]  iControlSignal,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  output logic [31:0] oHI,
  output logic [31:0] oLO
);

  logic [31:0] hi_q, lo_q;
  logic [31:0] hi_d, lo_d;

  logic signed [63:0] a_s64, b_s64, prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] a_mag, b_mag, q_mag, r_mag;
  logic        [31:0] q_s, r_s;

  always_comb begin
    a_s64  = {{32{iA[31]}}, iA};
    b_s64  = {{32{iB[31]}}, iB};
    prod_s = a_s64 * b_s64;
    prod_u = {32'h0, iA} * {32'h0, iB};

    // Signed division on magnitudes: 0x80000000 / -1 wraps back to 0x80000000.
    a_mag = iA[31] ? (32'h0 - iA) : iA;
    b_mag = iB[31] ? (32'h0 - iB) : iB;
    q_mag = (b_mag == 32'h0) ? 32'h0 : (a_mag / b_mag);
    r_mag = (b_mag == 32'h0) ? 32'h0 : (a_mag % b_mag);
    q_s   = (iA[31] ^ iB[31]) ? (32'h0 - q_mag) : q_mag;
    r_s   = iA[31] ? (32'h0 - r_mag) : r_mag;

    hi_d = hi_q;
    lo_d = lo_q;
    case (iControlSignal)
      OP_MTHI:  hi_d = iA;
      OP_MTLO:  lo_d = iA;
      OP_MULT:  {hi_d, lo_d} = prod_s;
      OP_MULTU: {hi_d, lo_d} = prod_u;
      OP_DIV: begin
        if (iB != 32'h0) begin
          hi_d = r_s;
          lo_d = q_s;
        end
      end
      OP_DIVU: begin
        if (iB != 32'h0) begin
          hi_d = iA % iB;
          lo_d = iA / iB;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      hi_q <= 32'h0;
      lo_q <= 32'h0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign oHI = hi_q;
  assign oLO = lo_q;

endmodule

// File: rtl/mips_alu.sv
// Combinational MIPS ALU with branch-support compares.
// Define MIPS_ALU_MULDIV_EN to add HI/LO registers and codes 17-24.
module mips_alu
  import mips_alu_pkg::*;
(
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [4:0]  iControlSignal,
  input  logic [31:0] iA,
  input  logic [31:0] iB,
  input  logic [4:0]  iShamt,
  output logic [31:0] oALUresult,
  output logic        oZero,
  output logic        oOverflow
);

  logic signed [31:0] a_s, b_s;
  logic        [31:0] sum, diff, hi, lo;
  logic        [31:0] result;
  logic               overflow;

  assign a_s  = iA;
  assign b_s  = iB;
  assign sum  = iA + iB;
  assign diff = iA - iB;

`ifdef MIPS_ALU_MULDIV_EN
  mips_alu_muldiv u_muldiv (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iControlSignal (iControlSignal),
    .iA             (iA),
    .iB             (iB),
    .oHI            (hi),
    .oLO            (lo)
  );
`else
  logic unused_clk_rst;
  assign unused_clk_rst = &{1'b0, iCLK, iRST};
  assign hi = 32'h0;
  assign lo = 32'h0;
`endif

  always_comb begin
    result   = 32'h0;
    overflow = 1'b0;
    case (iControlSignal)
      OP_AND:  result = iA & iB;
      OP_OR:   result = iA | iB;
      OP_NOR:  result = ~(iA | iB);
      OP_XOR:  result = iA ^ iB;
      OP_ADD: begin
        result   = sum;
        overflow = (iA[31] == iB[31]) && (sum[31] != iA[31]);
      end
      OP_ADDU: result = sum;
      OP_SUB: begin
        result   = diff;
        overflow = (iA[31] != iB[31]) && (diff[31] != iA[31]);
      end
      OP_SUBU: result = diff;
      OP_SLT:  result = {31'h0, a_s < b_s};
      OP_SLTU: result = {31'h0, iA < iB};
      OP_SLL:  result = iB << iShamt;
      OP_SRL:  result = iB >> iShamt;
      OP_SRA:  result = b_s >>> iShamt;
      OP_SLLV: result = iB << iA[4:0];
      OP_SRLV: result = iB >> iA[4:0];
      OP_SRAV: result = b_s >>> iA[4:0];
      OP_LUI:  result = {iB[15:0], 16'h0};
      // oZero then means bgez (SLTZ) or blez (SGTZ) taken.
      OP_SLTZ: result = {31'h0, iA[31]};
      OP_SGTZ: result = {31'h0, a_s > 32'sd0};
`ifdef MIPS_ALU_MULDIV_EN
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
`endif
      default: result = 32'h0;
    endcase
    if (is_hilo_write(iControlSignal))
      result = 32'h0;
  end

  assign oALUresult = result;
  assign oZero      = (result == 32'h0);
  assign oOverflow  = overflow;

endmodule

// File: tb/tb_mips_alu.sv
// Directed-vector bench for mips_alu; HI/LO steps run only when MIPS_ALU_MULDIV_EN is defined.
module tb_mips_alu;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [4:0]  iControlSignal;
  logic [31:0] iA, iB;
  logic [4:0]  iShamt;
  logic [31:0] oALUresult;
  logic        oZero, oOverflow;

  int checks = 0;
  int errors = 0;

  mips_alu dut (
    .iCLK           (iCLK),
    .iRST           (iRST),
    .iControlSignal (iControlSignal),
    .iA             (iA),
    .iB             (iB),
    .iShamt         (iShamt),
    .oALUresult     (oALUresult),
    .oZero          (oZero),
    .oOverflow      (oOverflow)
  );

  initial forever #5 iCLK = ~iCLK;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply a combinational vector and let it settle.
  task automatic apply(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh);
    iControlSignal = op;
    iA = a;
    iB = b;
    iShamt = sh;
    #1;
  endtask

  // Hold a HI/LO-writing code across one rising edge.
  task automatic wr(input string tag, input logic [4:0] op, input logic [31:0] a,
                    input logic [31:0] b);
    apply(op, a, b, 5'd0);
    chk32(tag, oALUresult, 32'h0);
    @(posedge iCLK);
    #1;
  endtask

  initial begin
    iRST = 1'b1;
    apply(5'd0, 32'h0, 32'h0, 5'd0);
    @(posedge iCLK);
    @(posedge iCLK);
    #1;
    iRST = 1'b0;

    apply(5'd0, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    chk32("and", oALUresult, 32'h00F0_1200);
    apply(5'd1, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    chk32("or", oALUresult, 32'hFFF0_FF34);
    apply(5'd8, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    chk32("nor", oALUresult, 32'h000F_00CB);
    apply(5'd9, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd0);
    chk32("xor", oALUresult, 32'hFF00_ED34);

    apply(5'd2, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk32("add_res", oALUresult, 32'h8000_0000);
    chk1("add_ov", oOverflow, 1'b1);
    apply(5'd3, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk32("addu_res", oALUresult, 32'h8000_0000);
    chk1("addu_ov", oOverflow, 1'b0);
    apply(5'd2, 32'hFFFF_FFFF, 32'h1, 5'd0);
    chk1("add_noov_zero", oZero, 1'b1);
    chk1("add_noov", oOverflow, 1'b0);

    apply(5'd4, 32'h5, 32'h5, 5'd0);
    chk32("sub_res", oALUresult, 32'h0);
    chk1("sub_zero", oZero, 1'b1);
    chk1("sub_ov0", oOverflow, 1'b0);
    apply(5'd4, 32'h8000_0000, 32'h1, 5'd0);
    chk32("sub_wrap", oALUresult, 32'h7FFF_FFFF);
    chk1("sub_ov1", oOverflow, 1'b1);
    apply(5'd5, 32'h8000_0000, 32'h1, 5'd0);
    chk1("subu_ov", oOverflow, 1'b0);

    apply(5'd6, 32'hFFFF_FFFF, 32'h1, 5'd0);
    chk32("slt", oALUresult, 32'h1);
    apply(5'd7, 32'hFFFF_FFFF, 32'h1, 5'd0);
    chk32("sltu", oALUresult, 32'h0);
    chk1("sltu_zero", oZero, 1'b1);

    apply(5'd12, 32'h0, 32'h8000_0000, 5'd4);
    chk32("sra", oALUresult, 32'hF800_0000);
    apply(5'd10, 32'h0, 32'h1, 5'd31);
    chk32("sll", oALUresult, 32'h8000_0000);
    apply(5'd11, 32'h0, 32'h8000_0000, 5'd31);
    chk32("srl", oALUresult, 32'h1);
    apply(5'd14, 32'd36, 32'hF0, 5'd0);
    chk32("srlv", oALUresult, 32'h0F);
    apply(5'd13, 32'd4, 32'hF, 5'd9);
    chk32("sllv", oALUresult, 32'hF0);
    apply(5'd15, 32'd1, 32'h8000_0000, 5'd0);
    chk32("srav", oALUresult, 32'hC000_0000);
    apply(5'd16, 32'h0, 32'hABCD_1234, 5'd0);
    chk32("lui", oALUresult, 32'h1234_0000);

    apply(5'd25, 32'h0, 32'h0, 5'd0);
    chk1("sltz_0", oZero, 1'b1);
    apply(5'd25, 32'h8000_0000, 32'h0, 5'd0);
    chk32("sltz_neg", oALUresult, 32'h1);
    apply(5'd26, 32'h0, 32'h0, 5'd0);
    chk1("sgtz_0", oZero, 1'b1);
    apply(5'd26, 32'h5, 32'h0, 5'd0);
    chk1("sgtz_5", oZero, 1'b0);
    apply(5'd26, 32'hFFFF_FFFF, 32'h0, 5'd0);
    chk1("sgtz_neg", oZero, 1'b1);

    apply(5'd31, 32'h1, 32'h1, 5'd3);
    chk32("op31_res", oALUresult, 32'h0);
    chk1("op31_zero", oZero, 1'b1);
    chk1("op31_ov", oOverflow, 1'b0);
    apply(5'd27, 32'hFFFF_FFFF, 32'h1, 5'd0);
    chk32("op27_res", oALUresult, 32'h0);

`ifdef MIPS_ALU_MULDIV_EN
    apply(5'd17, 32'h0, 32'h0, 5'd0);
    chk32("hi_after_reset", oALUresult, 32'h0);

    wr("mult_res", 5'd21, 32'hFFFF_FFFD, 32'd7);
    apply(5'd17, 32'h0, 32'h0, 5'd0);
    chk32("mult_hi", oALUresult, 32'hFFFF_FFFF);
    apply(5'd18, 32'h0, 32'h0, 5'd0);
    chk32("mult_lo", oALUresult, 32'hFFFF_FFEB);

    wr("multu_res", 5'd22, 32'hFFFF_FFFF, 32'd2);
    apply(5'd17, 32'h0, 32'h0, 5'd0);
    chk32("multu_hi", oALUresult, 32'h1);
    apply(5'd18, 32'h0, 32'h0, 5'd0);
    chk32("multu_lo", oALUresult, 32'hFFFF_FFFE);

    wr("div_res", 5'd23, 32'hFFFF_FFF9, 32'd2);
    apply(5'd18, 32'h0, 32'h0, 5'd0);
    chk32("div_lo", oALUresult, 32'hFFFF_FFFD);
    apply(5'd17, 32'h0, 32'h0, 5'd0);
    chk32("div_hi", oALUresult, 32'hFFFF_FFFF);

    wr("divu_res", 5'd24, 32'd7, 32'd2);
    apply(5'd18, 32'h0, 32'h0, 5'd0);
    chk32("divu_lo", oALUresult, 32'h3);
    apply(5'd17, 32'h0, 32'h0, 5'd0);
    chk32("divu_hi", oALUresult, 32'h1);

    wr("div_min_res", 5'd23, 32'h8000_0000, 32'hFFFF_FFFF);
    apply(5'd18, 32'h0, 32'h0, 5'd0);
    chk32("div_min_lo", oALUresult, 32'h8000_0000);
    apply(5'd17, 32'h0, 32'h0, 5'd0);
    chk32("div_min_hi", oALUresult, 32'h0);

    wr("mthi_res", 5'd19, 32'h1234, 32'h0);
    wr("mtlo_res", 5'd20, 32'h5678, 32'h0);
    wr("divu0_res", 5'd24, 32'd99, 32'h0);
    apply(5'd17, 32'h0, 32'h0, 5'd0);
    chk32("divu0_hi", oALUresult, 32'h1234);
    apply(5'd18, 32'h0, 32'h0, 5'd0);
    chk32("divu0_lo", oALUresult, 32'h5678);

    // Reset wins over a simultaneous MTLO.
    iRST = 1'b1;
    apply(5'd20, 32'hDEAD_BEEF, 32'h0, 5'd0);
    @(posedge iCLK);
    #1;
    apply(5'd18, 32'h0, 32'h0, 5'd0);
    chk32("rst_lo", oALUresult, 32'h0);
    iRST = 1'b0;
    apply(5'd17, 32'h0, 32'h0, 5'd0);
    chk32("rst_hi", oALUresult, 32'h0);
    chk1("rst_hi_zero", oZero, 1'b1);
`else
    for (int op = 17; op <= 24; op++) begin
      apply(op[4:0], 32'h1234_5678, 32'h3, 5'd0);
      chk32("nomuldiv_res", oALUresult, 32'h0);
      chk1("nomuldiv_zero", oZero, 1'b1);
      @(posedge iCLK);
      #1;
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mips_alu.md
MIPS_ALU -- requirements
Module: mips_alu

Interface
REQ-001 SHALL have ports: iCLK  in  1  clock, rising edge; iRST  in  1  reset, synchronous, active-high.
REQ-002 SHALL have ports: iControlSignal  in  5  operation code; iA  in  32  operand A (rs); iB  in  32  operand B (rt or extended immediate).
REQ-003 SHALL have ports: iShamt  in  5  constant shift amount; oALUresult  out  32  result; oZero  out  1  result==0; oOverflow  out  1  signed overflow.
REQ-004 SHALL have no parameters; all operation codes SHALL be fixed constants.

Function
REQ-005 oALUresult, oZero and oOverflow SHALL be combinational from the current inputs and the HI/LO state, with zero latency.
REQ-006 Logic codes SHALL be: 0 AND, 1 OR, 8 NOR, 9 XOR.
REQ-007 Arithmetic codes SHALL be: 2 ADD, 3 ADDU, 4 SUB, 5 SUBU, all modulo 2^32.
REQ-008 Compare codes SHALL be: 6 SLT signed, 7 SLTU unsigned, producing 32'd1 or 32'd0.
REQ-009 Constant shifts by iShamt SHALL be: 10 SLL, 11 SRL, 12 SRA.
REQ-010 Variable shifts by iA[4:0] applied to iB SHALL be: 13 SLLV, 14 SRLV, 15 SRAV.
REQ-011 Code 16 LUI SHALL produce {iB[15:0],16'h0}.
REQ-012 Branch-support codes SHALL be: 25 SLTZ = {31'b0, iA[31]}; 26 SGTZ = 1 if signed iA>0, else 0.
REQ-013 Codes 25 and 26 SHALL be decoded so that oZero=1 means bgez/blez taken.
REQ-014 oOverflow SHALL be 1 only for ADD when operand signs match and the result sign differs.
REQ-015 oOverflow SHALL be 1 only for SUB when operand signs differ and the result sign differs from iA; it SHALL be 0 for every other code.
REQ-016 oZero SHALL equal (oALUresult == 32'h0) for every code.
REQ-017 Unassigned codes SHALL give oALUresult=0, so oZero=1, with oOverflow=0.
REQ-018 HI/LO codes (under MULDIV_EN): 17 MFHI and 18 MFLO SHALL output HI or LO.
REQ-019 19 MTHI and 20 MTLO SHALL load iA into HI or LO at the next rising edge.
REQ-020 21 MULT signed and 22 MULTU SHALL write {HI,LO} with the 64-bit product at the next rising edge.
REQ-021 23 DIV signed and 24 DIVU SHALL write LO=quotient and HI=remainder at the next rising edge.
REQ-022 DIV SHALL truncate the quotient toward zero, and the remainder SHALL take the sign of the dividend.
REQ-023 Division by zero SHALL leave HI and LO unchanged.
REQ-024 DIV 0x80000000 / -1 SHALL give LO=0x80000000, HI=0.
REQ-025 HI/LO-writing codes SHALL output oALUresult=0.
REQ-026 HI/LO SHALL be written on every rising edge while the code is present; there is no handshake and no multi-cycle stall.
REQ-027 MFHI/MFLO issued in the cycle after a write SHALL return the new value.

Reset
REQ-028 When iRST=1 at a rising edge, HI and LO SHALL become 0, and reset SHALL take priority over any simultaneous HI/LO write.
REQ-029 Outputs SHALL remain combinational during reset; only MFHI/MFLO reflect the cleared state.

Configuration
REQ-030 Macro MIPS_ALU_MULDIV_EN defined: HI/LO registers and codes 17-24 SHALL be implemented per REQ-018..REQ-027.
REQ-031 Macro MIPS_ALU_MULDIV_EN undefined: no HI/LO storage SHALL exist, and codes 17-24 SHALL behave as unassigned codes (REQ-017).

Structure
REQ-032 Operation-code localparams 0-26 SHALL live in shared package mips_alu_pkg, used by the ALU and the ALU control decoder.
REQ-033 Multiply/divide and HI/LO storage SHALL be one sub-module, mips_alu_muldiv, instantiated only under MIPS_ALU_MULDIV_EN.

Verification
REQ-034 ADD: iA=0x7FFFFFFF, iB=1 -> oALUresult=0x80000000, oOverflow=1; ADDU with the same operands -> oOverflow=0.
REQ-035 SUB: iA=5, iB=5 -> oALUresult=0, oZero=1; SLT: iA=0xFFFFFFFF, iB=1 -> 1; SLTU with the same operands -> 0.
REQ-036 SRA: iB=0x80000000, iShamt=4 -> 0xF8000000; SRLV: iA=36, iB=0xF0 -> 0x0F (uses iA[4:0]=4).
REQ-037 MULT: iA=-3, iB=7, then MFHI -> 0xFFFFFFFF and MFLO -> 0xFFFFFFEB; DIV: iA=-7, iB=2, then MFLO -> 0xFFFFFFFD and MFHI -> 0xFFFFFFFF.
REQ-038 DIVU by 0 after MTHI 0x1234 -> HI stays 0x1234; iRST pulse -> MFHI -> 0.
REQ-039 SLTZ: iA=0 -> oZero=1; SGTZ: iA=0 -> oZero=1; SGTZ: iA=5 -> oZero=0; code 31 -> oALUresult=0, oZero=1.
